inst_fetch: RTL
===============

# inst_fetch

Instruction fetch front end for the single-cycle/multi-cycle CPU family: owns the fetch PC, issues read requests to instruction memory over a req/ready handshake, and holds each returned word in an instruction register until the decode stage accepts it. It is the initiator side of the instruction-memory interface, the counterpart to the memory model that answers a PC with a 32-bit instruction. Control-flow changes arrive as a redirect with a target PC.

## Interface
- RESET_PC, 32'h0000_0000, fetch address after reset
- CNT_W, 16, width of retired-fetch counter
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- imem_req  out  1  fetch request to instruction memory
- imem_addr  out  32  fetch address, word aligned
- imem_ready  in  1  memory has valid data this cycle
- imem_data  in  32  instruction word, sampled when imem_req & imem_ready
- inst_valid  out  1  inst_out/inst_pc hold a valid instruction
- inst_out  out  32  fetched instruction
- inst_pc  out  32  address the instruction came from
- inst_accept  in  1  decode consumes instruction (effective only with inst_valid)
- redirect  in  1  one-cycle pulse: next fetch from redirect_pc
- redirect_pc  in  32  redirect target
- PC_out  out  32  next address to be fetched
- misalign_err  out  1  sticky: a redirect target had bits [1:0] != 0
- fetch_cnt  out  CNT_W  count of accepted instructions, wraps

## Operation
- States: IDLE, REQ, HOLD.
- Reset (reset=0, async): state IDLE, PC_out=RESET_PC, imem_req=0, imem_addr=RESET_PC, inst_valid=0, inst_out=0, inst_pc=0, misalign_err=0, fetch_cnt=0, kill=0.
- IDLE: one cycle after reset release -> REQ.
- REQ: imem_req=1, imem_addr=PC_out, both stable until imem_ready. On imem_ready: if kill=0 capture imem_data->inst_out, PC_out->inst_pc, PC_out+=4, -> HOLD; if kill=1 discard data, clear kill, stay REQ at already-loaded redirect PC.
- HOLD: imem_req=0, inst_valid=1. On inst_accept: inst_valid=0, fetch_cnt+=1, -> REQ.
- PC arithmetic: modulo 2^32; 32'hFFFF_FFFC + 4 = 32'h0000_0000.
- Redirect target: PC := {redirect_pc[31:2],2'b00}; if redirect_pc[1:0]!=0 set misalign_err (cleared only by reset).
- Redirect in IDLE: PC loaded, proceed normally.
- Redirect in REQ with imem_ready=0: address must not change mid-transaction; latch target into PC_out, set kill; imem_addr keeps old address until ready, then discarded.
- Redirect in REQ with imem_ready=1: data discarded, PC loaded, stay REQ; new address next cycle.
- Redirect in HOLD: inst_valid dropped next cycle (instruction squashed, fetch_cnt unchanged even if inst_accept same cycle), PC loaded, -> REQ.
- imem_ready while imem_req=0: ignored.

## Timing
- Zero-wait memory (ready same cycle as req): req cycle N, inst_valid cycle N+1; throughput one instruction per 2 cycles with immediate accept.
- W wait cycles add W cycles latency.
- Redirect to first request of target: 1 cycle (imem_ready=1 or HOLD), else after pending transaction completes plus 1 cycle.
- All outputs registered except imem_req/imem_addr decoded from state registers (no input-to-output combinational path).
- Reset mid-transaction: outputs return to reset values immediately; memory must tolerate imem_req dropping without ready.

## Structure
- Shared package cpu_pkg: fetch state encoding (IDLE=2'd0, REQ=2'd1, HOLD=2'd2), INST_W=32, PC_STEP=4, NOP=32'h0000_0000.
- Single module; no sub-module needed. PC register, kill flag, IR and counter in one always block per register group.

## Test plan
- Reset release, zero-wait memory returning 32'h20080005 at 0x0 -> imem_req at cycle 1 addr 0x0, inst_valid cycle 2 with inst_out=32'h20080005, inst_pc=0x0, PC_out=0x4.
- Stream 0x0..0x1C (words 20080005, 20090001, 200B0002, 01095020, 000A50C0, 3C0C000A, 00006820, 0C000001), accept always high -> 8 instructions in order, fetch_cnt=8, one every 2 cycles.
- 3 wait cycles at 0x8 with redirect to 0x40 in first wait cycle -> imem_addr stays 0x8 until ready, data discarded, next request addr 0x40, no inst_valid for 0x8.
- Redirect to 0x43 while HOLD with inst_accept=1 -> instruction squashed, fetch_cnt unchanged, next fetch 0x40, misalign_err=1 and stays 1.
- Redirect to 0xFFFF_FFFC, accept -> next imem_addr 0x0000_0000.
- Assert reset low mid-REQ with imem_ready=0 -> imem_req=0, inst_valid=0, PC_out=RESET_PC asynchronously; fetch resumes at RESET_PC after release.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU family front end: fetch FSM encoding,
// instruction width and PC arithmetic helpers.
package cpu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_HOLD = 2'd2
  } fetch_state_e;

  localparam int                INST_W  = 32;
  localparam logic [31:0]       PC_STEP = 32'd4;
  localparam logic [INST_W-1:0] NOP     = 32'h0000_0000;

  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/inst_fetch.sv
// Instruction fetch front end: owns the fetch PC, runs the req/ready handshake
// with instruction memory and holds each fetched word until decode accepts it.
module inst_fetch
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [31:0]       imem_addr,
  input  logic              imem_ready,
  input  logic [INST_W-1:0] imem_data,
  output logic              inst_valid,
  output logic [INST_W-1:0] inst_out,
  output logic [31:0]       inst_pc,
  input  logic              inst_accept,
  input  logic              redirect,
  input  logic [31:0]       redirect_pc,
  output logic [31:0]       PC_out,
  output logic              misalign_err,
  output logic [CNT_W-1:0]  fetch_cnt
);

  fetch_state_e      r_state, w_state_nxt;
  logic [31:0]       r_pc, w_pc_nxt;
  logic [31:0]       r_addr, w_addr_nxt;
  logic              r_kill, w_kill_nxt;
  logic              w_capture, w_retire, w_leave_hold;
  logic [31:0]       w_redir_tgt;
  logic [INST_W-1:0] r_inst;
  logic [31:0]       r_inst_pc;
  logic              r_valid;
  logic              r_misalign;
  logic [CNT_W-1:0]  r_cnt;

  assign w_redir_tgt = align_pc(redirect_pc);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // NOTE: every signal driven here is defaulted first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_kill_nxt  = r_kill;
    w_capture   = 1'b0;
    w_retire    = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        w_state_nxt = ST_REQ;
        if (redirect) w_pc_nxt = w_redir_tgt;
      end
      ST_REQ: begin
        if (imem_ready) begin
          if (redirect) begin
            w_pc_nxt   = w_redir_tgt;
            w_kill_nxt = 1'b0;
          end else if (r_kill) begin
            w_kill_nxt = 1'b0;
          end else begin
            w_capture   = 1'b1;
            w_pc_nxt    = r_pc + PC_STEP;
            w_state_nxt = ST_HOLD;
          end
        end else if (redirect) begin
          // Outstanding transaction keeps its address; its data is dropped later.
          w_pc_nxt   = w_redir_tgt;
          w_kill_nxt = 1'b1;
        end
      end
      ST_HOLD: begin
        if (redirect) begin
          w_pc_nxt    = w_redir_tgt;
          w_state_nxt = ST_REQ;
        end else if (inst_accept) begin
          w_retire    = 1'b1;
          w_state_nxt = ST_REQ;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // The bus address only moves once no transaction is pending.
  assign w_addr_nxt   = (r_state == ST_REQ && !imem_ready) ? r_addr : w_pc_nxt;
  assign w_leave_hold = (r_state == ST_HOLD) && (w_state_nxt != ST_HOLD);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc   <= RESET_PC;
      r_addr <= RESET_PC;
      r_kill <= 1'b0;
    end else begin
      r_pc   <= w_pc_nxt;
      r_addr <= w_addr_nxt;
      r_kill <= w_kill_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_inst    <= NOP;
      r_inst_pc <= '0;
      r_valid   <= 1'b0;
    end else if (w_capture) begin
      r_inst    <= imem_data;
      r_inst_pc <= r_pc;
      r_valid   <= 1'b1;
    end else if (w_leave_hold) begin
      r_valid   <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_misalign <= 1'b0;
      r_cnt      <= '0;
    end else begin
      if (redirect && (redirect_pc[1:0] != 2'b00)) r_misalign <= 1'b1;
      if (w_retire) r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign imem_req     = (r_state == ST_REQ);
  assign imem_addr    = r_addr;
  assign inst_valid   = r_valid;
  assign inst_out     = r_inst;
  assign inst_pc      = r_inst_pc;
  assign PC_out       = r_pc;
  assign misalign_err = r_misalign;
  assign fetch_cnt    = r_cnt;

endmodule
